// File: rtl/router_pkg.sv
// rtl/router_pkg.sv - shared sizes and types for the packet tx serializer
package router_pkg;

  localparam int PKT_W     = 55;
  localparam int FLIT_W    = 11;
  localparam int NUM_FLITS = 5;
  localparam int CNT_W     = $clog2(NUM_FLITS);

  typedef enum logic [1:0] {IDLE, WAIT_TOKEN, SEND, PASS} tx_state_t;

  typedef logic [FLIT_W-1:0] flit_t;
  typedef logic [PKT_W-1:0]  pkt_t;
  typedef logic [CNT_W-1:0]  cnt_t;

  localparam cnt_t LAST_CNT = cnt_t'(NUM_FLITS - 1);

endpackage

// File: rtl/packet_tx_serializer_if.sv
// rtl/packet_tx_serializer_if.sv - buffer, token ring and link signals of the serializer
interface packet_tx_serializer_if;
  import router_pkg::*;

  pkt_t  pkt_in;
  logic  pkt_valid;
  logic  pkt_ready;
  logic  token_in;
  logic  token_out;
  flit_t tx_data;
  logic  tx_valid;
  logic  tx_first;
  logic  tx_last;
  logic  tx_ready;
  logic  busy;
  logic  token_err;

  // Environment side: packet buffer, upstream token, link driver
  modport master (
    output pkt_in, pkt_valid, token_in, tx_ready,
    input  pkt_ready, token_out, tx_data, tx_valid, tx_first, tx_last, busy, token_err
  );

  // Serializer side
  modport slave (
    input  pkt_in, pkt_valid, token_in, tx_ready,
    output pkt_ready, token_out, tx_data, tx_valid, tx_first, tx_last, busy, token_err
  );

endinterface

// File: rtl/flit_mux.sv
// rtl/flit_mux.sv - picks one flit out of a packet, most significant flit first
module flit_mux
  import router_pkg::*;
(
  input  pkt_t  pkt,
  input  cnt_t  cnt,
  output flit_t flit
);

  // Flit index 0 is the top FLIT_W bits; out-of-range indices give zero
  always_comb begin
    flit = '0;
    for (int i = 0; i < NUM_FLITS; i++) begin
      if (cnt == cnt_t'(i)) flit = pkt[PKT_W-1-FLIT_W*i -: FLIT_W];
    end
  end

endmodule

// File: rtl/packet_tx_serializer.sv
// rtl/packet_tx_serializer.sv - drains one buffered packet as flits once the ring token arrives
module packet_tx_serializer
  import router_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  packet_tx_serializer_if.slave  bus
);

  tx_state_t state;
  pkt_t      pkt_reg;
  cnt_t      flit_cnt;
  flit_t     tx_data_q;
  logic      tx_valid_q;
  logic      tx_first_q;
  logic      tx_last_q;
  logic      token_out_q;
  logic      token_err_q;

  cnt_t      sel_cnt;
  pkt_t      sel_pkt;
  flit_t     next_flit;

  assign bus.pkt_ready = (state == IDLE);
  assign bus.busy      = (state == WAIT_TOKEN) || (state == SEND);
  assign bus.token_out = token_out_q;
  assign bus.tx_data   = tx_data_q;
  assign bus.tx_valid  = tx_valid_q;
  assign bus.tx_first  = tx_first_q;
  assign bus.tx_last   = tx_last_q;
  assign bus.token_err = token_err_q;

  // Flit index that will be on the link next cycle; the packet source is the
  // input bus while idle so a same-cycle accept+token can show flit 0 at once
  always_comb begin
    sel_cnt = '0;
    sel_pkt = (state == IDLE) ? bus.pkt_in : pkt_reg;
    if (state == SEND) begin
      if (bus.tx_ready && (flit_cnt != LAST_CNT)) sel_cnt = flit_cnt + cnt_t'(1);
      else                                        sel_cnt = flit_cnt;
    end
  end

  flit_mux u_flit_mux (
    .pkt  (sel_pkt),
    .cnt  (sel_cnt),
    .flit (next_flit)
  );

  // Control FSM with registered link and token outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      pkt_reg     <= '0;
      flit_cnt    <= '0;
      tx_data_q   <= '0;
      tx_valid_q  <= 1'b0;
      tx_first_q  <= 1'b0;
      tx_last_q   <= 1'b0;
      token_out_q <= 1'b0;
      token_err_q <= 1'b0;
    end else begin
      token_out_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.pkt_valid) begin
            pkt_reg <= bus.pkt_in;
            if (bus.token_in) begin
              // Token arrives with the packet: keep it and start sending
              state      <= SEND;
              flit_cnt   <= sel_cnt;
              tx_valid_q <= 1'b1;
              tx_first_q <= 1'b1;
              tx_last_q  <= (sel_cnt == LAST_CNT);
              tx_data_q  <= next_flit;
            end else begin
              state <= WAIT_TOKEN;
            end
          end else if (bus.token_in) begin
            token_out_q <= 1'b1;
          end
        end
        WAIT_TOKEN: begin
          if (bus.token_in) begin
            state      <= SEND;
            flit_cnt   <= sel_cnt;
            tx_valid_q <= 1'b1;
            tx_first_q <= 1'b1;
            tx_last_q  <= (sel_cnt == LAST_CNT);
            tx_data_q  <= next_flit;
          end
        end
        SEND: begin
          if (bus.token_in) token_err_q <= 1'b1;
          if (bus.tx_ready) begin
            if (flit_cnt == LAST_CNT) begin
              state       <= PASS;
              flit_cnt    <= '0;
              tx_valid_q  <= 1'b0;
              tx_first_q  <= 1'b0;
              tx_last_q   <= 1'b0;
              tx_data_q   <= '0;
              token_out_q <= 1'b1;
            end else begin
              flit_cnt   <= sel_cnt;
              tx_first_q <= 1'b0;
              tx_last_q  <= (sel_cnt == LAST_CNT);
              tx_data_q  <= next_flit;
            end
          end
        end
        PASS: begin
          if (bus.token_in) token_err_q <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_packet_tx_serializer.sv
// tb/tb_packet_tx_serializer.sv - directed and random checks of the packet tx serializer
module tb_packet_tx_serializer;
  import router_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  packet_tx_serializer_if bus ();

  packet_tx_serializer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors     = 0;
  int miscompares = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic flit_t exp_flit(input pkt_t p, input int i);
    pkt_t s;
    s = p >> (FLIT_W * (NUM_FLITS - 1 - i));
    return flit_t'(s);
  endfunction

  function automatic pkt_t rand_pkt();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    return pkt_t'(r);
  endfunction

  task automatic token_pass;
    bus.token_in = 1'b1;
    tick;
    bus.token_in = 1'b0;
    chk("pass_token_out", bus.token_out, 1'b1);
    chk("pass_tx_valid", bus.tx_valid, 1'b0);
    chk("pass_busy", bus.busy, 1'b0);
    tick;
    chk("pass_token_out_clear", bus.token_out, 1'b0);
    chk("pass_ready", bus.pkt_ready, 1'b1);
  endtask

  task automatic send_packet(input pkt_t pkt, input int tok_delay, input int stall_flit,
                             input int stall_n, input bit bp_rand, input bit err_tok);
    int stalls_total;
    int tok_cyc;
    int s;
    stalls_total = 0;
    tok_cyc = 0;
    chk("accept_ready", bus.pkt_ready, 1'b1);
    bus.pkt_in    = pkt;
    bus.pkt_valid = 1'b1;
    bus.token_in  = (tok_delay == 0);
    if (tok_delay == 0) tok_cyc = cyc;
    tick;
    bus.pkt_valid = 1'b0;
    bus.token_in  = 1'b0;
    bus.pkt_in    = rand_pkt();
    if (tok_delay > 0) begin
      for (int k = 1; k < tok_delay; k++) begin
        chk("wait_busy", bus.busy, 1'b1);
        chk("wait_ready", bus.pkt_ready, 1'b0);
        chk("wait_tx_valid", bus.tx_valid, 1'b0);
        tick;
      end
      chk("wait_busy", bus.busy, 1'b1);
      bus.token_in = 1'b1;
      tok_cyc = cyc;
      tick;
      bus.token_in = 1'b0;
    end
    for (int i = 0; i < NUM_FLITS; i++) begin
      if (i == stall_flit) s = stall_n;
      else if (bp_rand && ($urandom_range(0, 3) == 0)) s = int'($urandom_range(1, 2));
      else s = 0;
      stalls_total += s;
      for (int c = 0; c <= s; c++) begin
        bus.tx_ready = (c == s);
        chk($sformatf("flit%0d_valid", i), bus.tx_valid, 1'b1);
        chk($sformatf("flit%0d_data", i), bus.tx_data, exp_flit(pkt, i));
        chk($sformatf("flit%0d_first", i), bus.tx_first, (i == 0));
        chk($sformatf("flit%0d_last", i), bus.tx_last, (i == NUM_FLITS - 1));
        chk($sformatf("flit%0d_token_out", i), bus.token_out, 1'b0);
        chk($sformatf("flit%0d_busy", i), bus.busy, 1'b1);
        if (err_tok && i == 2 && c == 0) bus.token_in = 1'b1;
        tick;
        bus.token_in = 1'b0;
      end
    end
    bus.tx_ready = 1'($urandom_range(0, 1));
    chk("done_token_out", bus.token_out, 1'b1);
    chk("done_token_latency", 64'(cyc - tok_cyc), 64'(NUM_FLITS + 1 + stalls_total));
    chk("done_tx_valid", bus.tx_valid, 1'b0);
    chk("done_ready", bus.pkt_ready, 1'b0);
    chk("done_busy", bus.busy, 1'b0);
    if (err_tok) chk("token_err_set", bus.token_err, 1'b1);
    tick;
    bus.tx_ready = 1'b1;
    chk("after_token_out", bus.token_out, 1'b0);
    chk("after_ready", bus.pkt_ready, 1'b1);
  endtask

  initial begin
    bus.pkt_in    = '0;
    bus.pkt_valid = 1'b0;
    bus.token_in  = 1'b0;
    bus.tx_ready  = 1'b1;

    // Reset state
    repeat (3) tick;
    chk("rst_tx_valid", bus.tx_valid, 1'b0);
    chk("rst_tx_data", bus.tx_data, '0);
    chk("rst_tx_first", bus.tx_first, 1'b0);
    chk("rst_tx_last", bus.tx_last, 1'b0);
    chk("rst_token_out", bus.token_out, 1'b0);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_token_err", bus.token_err, 1'b0);
    rst_n = 1'b1;
    tick;
    chk("rst_release_ready", bus.pkt_ready, 1'b1);

    // Token pass-through while idle
    while (cyc < 10) tick;
    token_pass;

    // Basic send, token three cycles after accept
    send_packet(55'h12_3456_789A_BCDE, 3, -1, 0, 1'b0, 1'b0);

    // Same packet with link stalled three cycles on flit 2
    send_packet(55'h12_3456_789A_BCDE, 3, 2, 3, 1'b0, 1'b0);

    // Accept and token in the same idle cycle
    send_packet(rand_pkt(), 0, -1, 0, 1'b0, 1'b0);

    // Random traffic
    for (int n = 0; n < 25; n++) begin
      if ($urandom_range(0, 3) == 0) token_pass;
      else send_packet(rand_pkt(), int'($urandom_range(0, 4)), -1, 0, 1'b1, 1'b0);
    end

    // Protocol error: extra token during SEND
    send_packet(rand_pkt(), 2, -1, 0, 1'b0, 1'b1);
    tick;
    chk("token_err_sticky", bus.token_err, 1'b1);

    // Asynchronous reset in the middle of SEND
    bus.pkt_in    = rand_pkt();
    bus.pkt_valid = 1'b1;
    bus.token_in  = 1'b1;
    tick;
    bus.pkt_valid = 1'b0;
    bus.token_in  = 1'b0;
    tick;
    chk("mid_send_valid", bus.tx_valid, 1'b1);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_tx_valid", bus.tx_valid, 1'b0);
    chk("arst_tx_data", bus.tx_data, '0);
    chk("arst_tx_first", bus.tx_first, 1'b0);
    chk("arst_tx_last", bus.tx_last, 1'b0);
    chk("arst_token_out", bus.token_out, 1'b0);
    chk("arst_busy", bus.busy, 1'b0);
    chk("arst_token_err", bus.token_err, 1'b0);
    tick;
    rst_n = 1'b1;
    tick;
    chk("post_arst_ready", bus.pkt_ready, 1'b1);
    chk("post_arst_tx_valid", bus.tx_valid, 1'b0);
    chk("post_arst_token_out", bus.token_out, 1'b0);
    send_packet(rand_pkt(), 1, -1, 0, 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
